// File: rtl/afp_pkg.sv
// Shared constants and width helpers for the AFP multiplier datapath.
package afp_pkg;

  localparam int AFP_DEFAULT_MW = 1;
  localparam int AFP_DEFAULT_OW = 2;

  // Width of a leading-zero count able to hold the value pw itself.
  function automatic int afp_lzc_w(input int pw);
    return $clog2(pw + 1);
  endfunction

endpackage

// File: rtl/afp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields PW.
module afp_lzc #(
  parameter int PW  = 4,
  parameter int LZW = 3
) (
  input  logic [PW-1:0]  a,
  output logic [LZW-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = LZW'(PW);
    found = 1'b0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (!found && a[PW-1-i]) begin
        cnt   = LZW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/afp_mult_pipe.sv
// Two-stage pipelined AFP multiplier with valid/ready flow control.
// Build option: AFP_DENORM_EN enables denormal significands (offset field all ones).
module afp_mult_pipe
  import afp_pkg::*;
#(
  parameter int MW = AFP_DEFAULT_MW,
  parameter int OW = AFP_DEFAULT_OW
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1+OW+MW-1:0]                x,
  input  logic [1+OW+MW-1:0]                y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              ps,
  output logic [OW:0]                       po,
  output logic [2*(MW+1)-1:0]               pm,
  output logic [2*(MW+1)-1:0]               pm_norm,
  output logic [afp_lzc_w(2*(MW+1))-1:0]    lzc,
  output logic                              zero
);

  localparam int SW  = MW + 1;
  localparam int W   = 1 + OW + MW;
  localparam int PW  = 2 * SW;
  localparam int LZW = afp_lzc_w(PW);

  logic          xs, ys;
  logic [OW-1:0] xo, yo;
  logic [MW-1:0] xf, yf;
  logic [SW-1:0] xsig, ysig;
  logic          ps_c;
  logic [OW:0]   po_c;
  logic [PW-1:0] pm_c;

  assign xs = x[W-1];
  assign ys = y[W-1];
  assign xo = x[W-2 -: OW];
  assign yo = y[W-2 -: OW];
  assign xf = x[MW-1:0];
  assign yf = y[MW-1:0];

`ifdef AFP_DENORM_EN
  assign xsig = (&xo) ? {xf, 1'b0} : {1'b1, xf};
  assign ysig = (&yo) ? {yf, 1'b0} : {1'b1, yf};
`else
  assign xsig = {1'b1, xf};
  assign ysig = {1'b1, yf};
`endif

  assign ps_c = xs ^ ys;
  assign po_c = {1'b0, xo} + {1'b0, yo};
  assign pm_c = PW'(xsig) * PW'(ysig);

  logic          v1, v2;
  logic          en1, en2;
  logic          s1_ps;
  logic [OW:0]   s1_po;
  logic [PW-1:0] s1_pm;

  // Each stage may advance when it is empty or its successor advances.
  assign en2       = ~v2 | out_ready;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      s1_ps <= 1'b0;
      s1_po <= '0;
      s1_pm <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_ps <= ps_c;
        s1_po <= po_c;
        s1_pm <= pm_c;
      end
    end
  end

  logic [LZW-1:0] lzc_c;
  logic [PW-1:0]  pm_norm_c;

  afp_lzc #(.PW(PW), .LZW(LZW)) u_lzc (
    .a   (s1_pm),
    .cnt (lzc_c)
  );

  assign pm_norm_c = s1_pm << lzc_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2      <= 1'b0;
      ps      <= 1'b0;
      po      <= '0;
      pm      <= '0;
      pm_norm <= '0;
      lzc     <= '0;
      zero    <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        ps      <= s1_ps;
        po      <= s1_po;
        pm      <= s1_pm;
        pm_norm <= pm_norm_c;
        lzc     <= lzc_c;
        zero    <= (s1_pm == '0);
      end
    end
  end

endmodule

// File: tb/tb_afp_mult_pipe.sv
// Self-checking bench for afp_mult_pipe at default widths (MW=1, OW=2).
module tb_afp_mult_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [3:0] x, y;
  logic       out_valid, out_ready;
  logic       ps;
  logic [2:0] po;
  logic [3:0] pm, pm_norm;
  logic [2:0] lzc;
  logic       zero;

  typedef struct packed {
    logic       ps;
    logic [2:0] po;
    logic [3:0] pm;
    logic [3:0] pm_norm;
    logic [2:0] lzc;
    logic       zero;
  } res_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    res_t       exp;
  } vec_t;

  res_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;

  afp_mult_pipe #(.MW(1), .OW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ps        (ps),
    .po        (po),
    .pm        (pm),
    .pm_norm   (pm_norm),
    .lzc       (lzc),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic res_t cur_res();
    return '{ps: ps, po: po, pm: pm, pm_norm: pm_norm, lzc: lzc, zero: zero};
  endfunction

  // Independent reference: unpack, multiply, count zeros by scanning.
  function automatic res_t model(input logic [3:0] a, input logic [3:0] b);
    res_t       r;
    logic [1:0] sa, sb;
    int         n;
    sa = {1'b1, a[0]};
    sb = {1'b1, b[0]};
`ifdef AFP_DENORM_EN
    if (a[2:1] == 2'b11) sa = {a[0], 1'b0};
    if (b[2:1] == 2'b11) sb = {b[0], 1'b0};
`endif
    r.ps = a[3] ^ b[3];
    r.po = 3'(a[2:1]) + 3'(b[2:1]);
    r.pm = 4'(sa) * 4'(sb);
    n = 0;
    while (n < 4 && r.pm[3-n] == 1'b0) n++;
    r.lzc     = 3'(n);
    r.pm_norm = 4'(r.pm << n);
    r.zero    = (r.pm == 4'b0000);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Scoreboard: every completed output handshake pops one expected record.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %h expected none", cur_res());
      end else begin
        check("result", 32'(cur_res()), 32'(q.pop_front()));
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input res_t e, output int stalls);
    bit done;
    done   = 0;
    stalls = 0;
    x = a; y = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        done = 1;
      end else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drained", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
  endtask

  vec_t vecs[5];
  res_t held;
  int   st, tot;
  int   out_snap;

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    #1 reset = 1'b1;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);

    vecs[0] = '{4'b0001, 4'b0011, '{1'b0, 3'b001, 4'b1001, 4'b1001, 3'd0, 1'b0}};
`ifdef AFP_DENORM_EN
    vecs[1] = '{4'b0111, 4'b0111, '{1'b0, 3'b110, 4'b0100, 4'b1000, 3'd1, 1'b0}};
    vecs[3] = '{4'b0110, 4'b0001, '{1'b0, 3'b011, 4'b0000, 4'b0000, 3'd4, 1'b1}};
`else
    vecs[1] = '{4'b0111, 4'b0111, '{1'b0, 3'b110, 4'b1001, 4'b1001, 3'd0, 1'b0}};
    vecs[3] = '{4'b0110, 4'b0001, '{1'b0, 3'b011, 4'b0110, 4'b1100, 3'd1, 1'b0}};
`endif
    vecs[2] = '{4'b1000, 4'b0000, '{1'b1, 3'b000, 4'b0100, 4'b1000, 3'd1, 1'b0}};
    vecs[4] = '{4'b0101, 4'b1010, '{1'b1, 3'b011, 4'b0110, 4'b1100, 3'd1, 1'b0}};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_outputs", 32'(cur_res()), 32'd0);
    @(posedge clk); #1;

    // Directed vectors; the first one also pins the two-cycle latency.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].x, vecs[i].y, vecs[i].exp, st);
      in_valid = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        check("latency_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_cycle2", 32'(out_valid), 32'd1);
      end
      drain();
    end

    // Backpressure: two accepted, third held until the sink frees up.
    out_ready = 1'b0;
    send(4'b0001, 4'b0011, model(4'b0001, 4'b0011), st);
    send(4'b1101, 4'b0100, model(4'b1101, 4'b0100), st);
    x = 4'b1010; y = 4'b0111; in_valid = 1'b1;
    @(negedge clk);
    held = cur_res();
    for (int i = 0; i < 3; i++) begin
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("stall_stable", 32'(cur_res()), 32'(held));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'b1010, 4'b0111, model(4'b1010, 4'b0111), st);
    check("full_push_pop_no_stall", 32'(st), 32'd0);
    in_valid = 1'b0;
    drain();

    // Streaming at full rate with random operands.
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      send(a, b, model(a, b), st);
      tot += st;
    end
    in_valid = 1'b0;
    check("stream_stalls", 32'(tot), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("stream_done_in_2", 32'(q.size()), 32'd0);

    // Asynchronous reset with both stages full and the sink stalled.
    out_ready = 1'b0;
    send(4'b0011, 4'b0101, model(4'b0011, 4'b0101), st);
    send(4'b1001, 4'b1111, model(4'b1001, 4'b1111), st);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_out_valid", 32'(out_valid), 32'd0);
    check("midrun_reset_outputs", 32'(cur_res()), 32'd0);
    q.delete();
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    out_snap = n_out;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_output", 32'(n_out - out_snap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
